// File: rtl/channel_scan_sequencer.sv
// ----------------------------------------------------------------------------
// channel_scan_sequencer
//
// Purpose:
//   Steps through a bank of counter channels. Each channel is held for
//   SLOT_TICKS advance events (adv = tick | tick_rtc), then the selection
//   moves to the next channel in cyclic order. The block emits a shift/load
//   pulse on the first advance of every slot, a frame_done pulse when the
//   channel index wraps, and an out_rst pulse when that wrap came from an
//   RTC overflow.
//
// Optional feature:
//   SCAN_MASK_EN - adds ch_mask; channels whose mask bit is 0 are skipped.
//                  The mask is looked at only on IDLE exit and on slot wrap.
//                  An all-zero mask keeps or returns the FSM to IDLE.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   enable     in   level, high = scan runs, low = return to IDLE
//   tick       in   counter-overflow advance strobe
//   tick_rtc   in   RTC-overflow advance strobe
//   ch_mask    in   [N_CH-1:0] per-channel enable (SCAN_MASK_EN only)
//   ch_addr    out  [AW-1:0] selected channel index
//   slot_cnt   out  [SW-1:0] advance count within the current slot
//   sl         out  shift/load pulse
//   frame_done out  pulse on channel-frame wrap
//   out_rst    out  pulse on frame wrap caused by tick_rtc
//   busy       out  high while in DWELL
//
// States:
//   IDLE  | scan stopped, ch_addr and slot_cnt held at 0
//   DWELL | dwelling on ch_addr, counting advances in slot_cnt
// ----------------------------------------------------------------------------
module channel_scan_sequencer #(
    parameter int N_CH       = 6,
    parameter int SLOT_TICKS = 12,
    localparam int AW = $clog2(N_CH),
    localparam int SW = $clog2(SLOT_TICKS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            tick,
    input  logic            tick_rtc,
`ifdef SCAN_MASK_EN
    input  logic [N_CH-1:0] ch_mask,
`endif
    output logic [AW-1:0]   ch_addr,
    output logic [SW-1:0]   slot_cnt,
    output logic            sl,
    output logic            frame_done,
    output logic            out_rst,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ch_addr_q, ch_addr_d;
    logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
    logic            sl_q, sl_d;
    logic            frame_done_q, frame_done_d;
    logic            out_rst_q, out_rst_d;

    logic            adv;
    logic            slot_last;
    logic [N_CH-1:0] mask_eff;
    logic            any_en;
    logic [AW-1:0]   first_ch;
    logic [AW-1:0]   next_ch;
    logic [AW-1:0]   cand;

    // Simultaneous strobes collapse into a single advance.
    assign adv       = tick | tick_rtc;
    assign slot_last = (slot_cnt_q == SW'(SLOT_TICKS - 1));

`ifdef SCAN_MASK_EN
    assign mask_eff = ch_mask;
`else
    assign mask_eff = '1;
`endif
    assign any_en = |mask_eff;

    // Lowest enabled channel: the starting point on IDLE exit.
    always_comb begin
        first_ch = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask_eff[k]) begin
                first_ch = AW'(k);
            end
        end
    end

    // Next enabled channel after ch_addr_q in cyclic order. Scanning the
    // offsets downward lets the nearest hit win. Offset N_CH lands back on
    // the current channel, so a single enabled channel selects itself and
    // every wrap of it becomes a frame wrap.
    always_comb begin
        next_ch = ch_addr_q;
        cand    = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = AW'((int'(ch_addr_q) + k) % N_CH);
            if (mask_eff[cand]) begin
                next_ch = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_addr_d    = ch_addr_q;
        slot_cnt_d   = slot_cnt_q;
        sl_d         = 1'b0;
        frame_done_d = 1'b0;
        out_rst_d    = 1'b0;

        case (state_q)
            IDLE: begin
                ch_addr_d  = '0;
                slot_cnt_d = '0;
                if (enable && any_en) begin
                    state_d   = DWELL;
                    ch_addr_d = first_ch;
                end
            end

            DWELL: begin
                if (!enable) begin
                    state_d    = IDLE;
                    ch_addr_d  = '0;
                    slot_cnt_d = '0;
                end else if (adv) begin
                    if (slot_last) begin
                        slot_cnt_d = '0;
                        if (!any_en) begin
                            // Mask cleared while scanning: stop at this wrap.
                            state_d   = IDLE;
                            ch_addr_d = '0;
                        end else begin
                            ch_addr_d    = next_ch;
                            frame_done_d = (next_ch <= ch_addr_q);
                            out_rst_d    = (next_ch <= ch_addr_q) && tick_rtc;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + SW'(1);
                        sl_d       = (slot_cnt_q == '0);
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                ch_addr_d  = '0;
                slot_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ch_addr_q    <= '0;
            slot_cnt_q   <= '0;
            sl_q         <= 1'b0;
            frame_done_q <= 1'b0;
            out_rst_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_addr_q    <= ch_addr_d;
            slot_cnt_q   <= slot_cnt_d;
            sl_q         <= sl_d;
            frame_done_q <= frame_done_d;
            out_rst_q    <= out_rst_d;
        end
    end

    assign ch_addr    = ch_addr_q;
    assign slot_cnt   = slot_cnt_q;
    assign sl         = sl_q;
    assign frame_done = frame_done_q;
    assign out_rst    = out_rst_q;
    assign busy       = (state_q == DWELL);

endmodule

// File: doc/channel_scan_sequencer.md
CHANNEL_SCAN_SEQUENCER -- requirements
Module: channel_scan_sequencer

Interface
REQ-001 Parameter N_CH, default 6: number of scanned counter channels; legal range 2..16.
REQ-002 Parameter SLOT_TICKS, default 12: advance events per channel slot; legal range 2..256.
REQ-003 Derived widths SHALL be AW = clog2(N_CH) and SW = clog2(SLOT_TICKS).
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 enable  in  1  level; high = scan runs, low = return to IDLE.
REQ-008 tick  in  1  counter-overflow advance strobe, one clk wide.
REQ-009 tick_rtc  in  1  RTC-overflow advance strobe, one clk wide.
REQ-010 ch_mask  in  N_CH  per-channel scan enable; present only with SCAN_MASK_EN.
REQ-011 ch_addr  out  AW  registered index of the channel currently selected.
REQ-012 slot_cnt  out  SW  registered advance count within the current slot.
REQ-013 sl  out  1  shift/load pulse, one clk wide.
REQ-014 frame_done  out  1  one-clk pulse when a full channel frame completes.
REQ-015 out_rst  out  1  one-clk pulse requesting a counter bank reset.
REQ-016 busy  out  1  high while the FSM is in DWELL.

Function
REQ-017 Advance event adv SHALL be (tick OR tick_rtc); simultaneous tick and tick_rtc SHALL count as one advance.
REQ-018 The FSM SHALL have two states, IDLE and DWELL; encoding is free, and no other reachable states are allowed.
REQ-019 IDLE -> DWELL SHALL occur on the first clk with enable=1 (and, with the mask, at least one enabled channel); ch_addr is set to the first enabled channel and slot_cnt=0.
REQ-020 DWELL -> IDLE SHALL occur on any clk with enable=0; ch_addr=0 and slot_cnt=0 on the next clk, and pulses are suppressed.
REQ-021 In DWELL, each adv SHALL increment slot_cnt; adv at slot_cnt=SLOT_TICKS-1 SHALL wrap slot_cnt to 0 and move ch_addr to the next enabled channel in cyclic order.
REQ-022 With no adv, slot_cnt and ch_addr SHALL hold.
REQ-023 sl SHALL be high for exactly the one clk following an adv that moves slot_cnt from 0 to 1.
REQ-024 frame_done SHALL pulse for the one clk following a slot wrap whose next channel index is <= the current index (frame wrap).
REQ-025 out_rst SHALL pulse in the same clk as frame_done only if tick_rtc=1 on the wrapping adv; a frame wrap caused by tick alone SHALL NOT assert out_rst.
REQ-026 All outputs SHALL be registered; latency from the adv edge to an ch_addr, slot_cnt, sl, frame_done or out_rst update is one clk.
REQ-027 busy SHALL equal (state == DWELL).

Reset
REQ-028 On a clk edge with reset_n=0, state SHALL be IDLE, with ch_addr=0, slot_cnt=0, sl=0, frame_done=0, out_rst=0 and busy=0.
REQ-029 Reset SHALL override enable, tick and tick_rtc, including mid-slot and on the wrapping cycle; no pulse may issue on the reset cycle or the cycle after.

Configuration
REQ-030 Macro SCAN_MASK_EN SHALL control channel masking.
REQ-031 With SCAN_MASK_EN defined, the ch_mask port SHALL exist, and channels with a 0 mask bit SHALL be skipped.
REQ-032 With SCAN_MASK_EN defined, ch_mask SHALL be sampled only at IDLE exit and at slot wrap.
REQ-033 With SCAN_MASK_EN defined, an all-zero mask SHALL hold or force the FSM in IDLE.
REQ-034 With SCAN_MASK_EN defined and exactly one enabled channel, every slot wrap SHALL be a frame wrap.
REQ-035 Without SCAN_MASK_EN, the ch_mask port SHALL be absent and all N_CH channels SHALL be scanned in order 0..N_CH-1.

Verification
REQ-036 Defaults; enable=1; 72 tick pulses -> ch_addr steps 0,1,2,3,4,5 every 12 ticks; sl pulses 6 times; frame_done once; out_rst never.
REQ-037 Defaults; as REQ-036 but the 72nd advance is tick_rtc -> frame_done and out_rst both pulse one clk; ch_addr=0, slot_cnt=0.
REQ-038 tick and tick_rtc high on the same clk at slot_cnt=3 -> slot_cnt=4, not 5.
REQ-039 Reset_n=0 at ch_addr=4, slot_cnt=7 -> next clk: all outputs 0, state IDLE; ticks are ignored while reset_n=0.
REQ-040 SCAN_MASK_EN, N_CH=6, ch_mask=6'b100101 -> ch_addr sequence 0,2,5,0; frame_done after the slot-5 wrap; ch_mask=0 -> busy=0.
REQ-041 enable dropped at ch_addr=3, slot_cnt=5 -> next clk IDLE, ch_addr=0, busy=0; re-enable restarts at channel 0, slot_cnt 0.
